// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL reset/lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 50;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  localparam logic [7:0] SAT_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous status inputs, cleared to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset pulse, qualifies lock, gates the downstream reset and
// latches a fault after repeated failed lock attempts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  output logic       pll_rst_o,
  output logic       downstream_rst_o,
  output logic       clk_ready_o,
  output logic       fault_o,
  output logic [3:0] retry_count_o,
  output logic [7:0] lock_loss_count_o
);

  localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES)) + 1;
  typedef logic [CW-1:0] cnt_t;

  // Counter holds the number of cycles already spent in the state, so the
  // last cycle of an N-cycle phase is the one with count N-1.
  localparam cnt_t RST_LAST     = cnt_t'(RST_PULSE_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  sup_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d, retry_inc;
  logic [7:0] loss_q, loss_d;
  logic       locked_s;
  logic       fail;

  logic pll_rst_q, pll_rst_d;
  logic dsr_q, dsr_d;
  logic rdy_q, rdy_d;
  logic fault_q, fault_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (refclk_i),
    .rst_i (rst_i),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  assign retry_inc = retry_q + 4'd1;

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      dsr_q     <= 1'b1;
      rdy_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      dsr_q     <= dsr_d;
      rdy_q     <= rdy_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    fail    = 1'b0;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins.
        if (locked_s)                  state_d = ST_STABILIZE;
        else if (cnt_q == TIMEOUT_LAST) fail   = 1'b1;
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          fail = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET_PLL;
          if (loss_q != SAT_MAX) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET_PLL;
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
    end

    if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAULT)
      cnt_d = '0;
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    dsr_d     = (state_d != ST_RUN);
    rdy_d     = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_rst_o         = pll_rst_q;
  assign downstream_rst_o  = dsr_q;
  assign clk_ready_o       = rdy_q;
  assign fault_o           = fault_q;
  assign retry_count_o     = retry_q;
  assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench: per-edge vector table for power-up/lock/loss, hand sequences
// for counter saturation, stabilize drop, mid-operation reset and fault.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, dsr, rdy, flt;
  logic [3:0] rc;
  logic [7:0] llc;
  logic [15:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  localparam int B_PLL = 15;
  localparam int B_RDY = 13;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk_i          (refclk),
    .rst_i             (rst),
    .locked_i          (locked),
    .pll_rst_o         (pll_rst),
    .downstream_rst_o  (dsr),
    .clk_ready_o       (rdy),
    .fault_o           (flt),
    .retry_count_o     (rc),
    .lock_loss_count_o (llc)
  );

  always #5 refclk = ~refclk;

  assign obs = {pll_rst, dsr, rdy, flt, rc, llc};

  typedef struct {
    int          n;
    logic        rst;
    logic        lck;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [15:0] mk(input logic p, input logic d, input logic r,
                                     input logic f, input logic [3:0] c,
                                     input logic [7:0] l);
    return {p, d, r, f, c, l};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {pll,dsr,rdy,flt,rc,llc}=%h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_bit(input int idx, input logic val, input int bound, input string nm);
    int k;
    k = 0;
    while (obs[idx] !== val && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (obs[idx] !== val) begin
      n_err++;
      $display("FAIL %s: output bit %0d is %b after %0d cycles, want %b", nm, idx, obs[idx], bound, val);
    end
  endtask

  initial begin
    logic [15:0] e;

    // Power-up, lock acquisition, one 3-cycle lock loss and re-lock.
    tbl[0] = '{3,  1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    tbl[1] = '{3,  1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    tbl[2] = '{5,  1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0)};
    tbl[3] = '{10, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0)};
    tbl[4] = '{5,  1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0)};
    tbl[5] = '{2,  1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0)};
    tbl[6] = '{1,  1'b0, 1'b0, mk(1, 1, 0, 0, 0, 1)};
    tbl[7] = '{3,  1'b0, 1'b1, mk(1, 1, 0, 0, 0, 1)};
    tbl[8] = '{9,  1'b0, 1'b1, mk(0, 1, 0, 0, 0, 1)};
    tbl[9] = '{3,  1'b0, 1'b1, mk(0, 0, 1, 0, 0, 1)};

    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        rst    = tbl[r].rst;
        locked = tbl[r].lck;
        tick();
        chk($sformatf("vec%0d.%0d", r, c), obs, tbl[r].exp);
      end
    end

    // Lock-loss counter saturation: losses 2..260.
    for (int i = 2; i <= 260; i++) begin
      locked = 1'b0;
      wait_bit(B_PLL, 1'b1, 10, $sformatf("loss%0d_pll_rst", i));
      if (i < 5) chk($sformatf("loss%0d_edge", i), {obs[15:12], 12'h0}, 16'hC000);
      locked = 1'b1;
      wait_bit(B_RDY, 1'b1, 40, $sformatf("relock%0d", i));
      if (i >= 254)
        chk($sformatf("llc_sat%0d", i), {8'h00, llc}, {8'h00, (i > 255) ? 8'd255 : 8'(i)});
    end

    rst = 1'b1;
    tick();
    chk("rst_clears_run", obs, mk(1, 1, 0, 0, 0, 0));

    // Lock dropped when the stabilize count is 5, then re-stabilize and reset mid-way.
    rst    = 1'b0;
    locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 9)  locked = 1'b0;
      if (k == 12) locked = 1'b1;
      tick();
      if (k <= 3)       e = mk(1, 1, 0, 0, 0, 0);
      else if (k <= 10) e = mk(0, 1, 0, 0, 0, 0);
      else if (k <= 14) e = mk(1, 1, 0, 0, 1, 0);
      else              e = mk(0, 1, 0, 0, 1, 0);
      chk($sformatf("stab_drop_k%0d", k), obs, e);
    end
    rst = 1'b1;
    tick();
    chk("rst_mid_stabilize", obs, mk(1, 1, 0, 0, 0, 0));

    // No lock ever: two timeouts then a sticky fault, even if lock appears later.
    rst    = 1'b0;
    locked = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      if (k == 80) locked = 1'b1;
      tick();
      if (k <= 3)       e = mk(1, 1, 0, 0, 0, 0);
      else if (k <= 23) e = mk(0, 1, 0, 0, 0, 0);
      else if (k <= 27) e = mk(1, 1, 0, 0, 1, 0);
      else if (k <= 47) e = mk(0, 1, 0, 0, 1, 0);
      else              e = mk(1, 1, 0, 1, 2, 0);
      chk($sformatf("fault_k%0d", k), obs, e);
    end
    rst = 1'b1;
    tick();
    chk("rst_clears_fault", obs, mk(1, 1, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
